// File: rtl/chan_bin_select.sv
// Channelizer bin selector: forwards only mask-enabled FFT bins and moves tlast onto the
// last enabled bin of each frame. The mask is double-banked so updates land on frame edges.
module chan_bin_select #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BIN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [23:0]           s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic [11:0]           fft_size,
  input  logic                  mask_wr_en,
  input  logic [BIN_WIDTH-1:0]  mask_wr_addr,
  input  logic                  mask_wr_data,
  input  logic                  mask_commit,
  output logic                  mask_busy,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [23:0]           m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [15:0]           frame_cnt
);
  localparam int unsigned Depth = 2 ** BIN_WIDTH;
  localparam logic [BIN_WIDTH-1:0] LastAddr = '1;

  typedef enum logic [1:0] {StInit, StSync, StRun} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                 active_sel_q, active_sel_d;
  logic                 commit_pend_q, commit_pend_d;
  logic [Depth-1:0]     mask_q [2];

  logic                  s1_valid_q, s1_valid_d, s1_en_q, s1_en_d, s1_last_q, s1_last_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [23:0]           s1_user_q, s1_user_d;
  logic                  h_valid_q, h_valid_d, h_last_q, h_last_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic [23:0]           h_user_q, h_user_d;
  logic                  o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [23:0]           o_user_q, o_user_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic                 adv, h_flush, proceed, swap;
  logic [BIN_WIDTH-1:0] s_bin;

  assign s_bin = s_axis_tuser[BIN_WIDTH-1:0];

  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    s1_valid_d    = s1_valid_q;
    s1_en_d       = s1_en_q;
    s1_last_d     = s1_last_q;
    s1_data_d     = s1_data_q;
    s1_user_d     = s1_user_q;
    h_valid_d     = h_valid_q;
    h_last_d      = h_last_q;
    h_data_d      = h_data_q;
    h_user_d      = h_user_q;
    o_valid_d     = o_valid_q;
    o_last_d      = o_last_q;
    o_data_d      = o_data_q;
    o_user_d      = o_user_q;
    adv           = !o_valid_q | m_axis_tready;
    h_flush       = h_valid_q & h_last_q;
    s_axis_tready = 1'b0;
    proceed       = 1'b0;

    case (state_q)
      StInit: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LastAddr) state_d = StSync;
      end
      StSync: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = StRun;
      end
      StRun: begin
        proceed       = adv & !h_flush;
        s_axis_tready = proceed;
      end
      default: state_d = StInit;
    endcase

    swap          = commit_pend_q & ((state_q == StSync) | (proceed & s1_valid_q & s1_last_q));
    active_sel_d  = active_sel_q ^ swap;
    commit_pend_d = swap ? 1'b0 : (commit_pend_q | mask_commit);

    // Look up with the post-swap bank: a bin 0 accepted alongside the swap belongs to the new mask
    if (proceed) begin
      s1_valid_d = s_axis_tvalid;
      if (s_axis_tvalid) begin
        s1_en_d   = mask_q[active_sel_d][s_bin] & (32'(s_bin) < 32'(fft_size));
        s1_last_d = s_axis_tlast;
        s1_data_d = s_axis_tdata;
        s1_user_d = s_axis_tuser;
      end
    end

    if (adv) begin
      o_valid_d = 1'b0;
      if (h_flush) begin
        o_valid_d = 1'b1;
        o_data_d  = h_data_q;
        o_user_d  = h_user_q;
        o_last_d  = 1'b1;
        h_valid_d = 1'b0;
      end else if (s1_valid_q) begin
        if (s1_en_q) begin
          if (h_valid_q) begin
            o_valid_d = 1'b1;
            o_data_d  = h_data_q;
            o_user_d  = h_user_q;
            o_last_d  = 1'b0;
          end
          h_valid_d = 1'b1;
          h_last_d  = s1_last_q;
          h_data_d  = s1_data_q;
          h_user_d  = s1_user_q;
        end else if (s1_last_q) begin
          if (h_valid_q) begin
            o_valid_d = 1'b1;
            o_data_d  = h_data_q;
            o_user_d  = h_user_q;
            o_last_d  = 1'b1;
          end
          h_valid_d = 1'b0;
        end
      end
    end

    frame_cnt_d = frame_cnt_q + 16'(o_valid_q & m_axis_tready & o_last_q);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q       <= StInit;
      init_addr_q   <= '0;
      active_sel_q  <= 1'b0;
      commit_pend_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      h_valid_q     <= 1'b0;
      o_valid_q     <= 1'b0;
      o_last_q      <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      init_addr_q   <= init_addr_d;
      active_sel_q  <= active_sel_d;
      commit_pend_q <= commit_pend_d;
      s1_valid_q    <= s1_valid_d;
      h_valid_q     <= h_valid_d;
      o_valid_q     <= o_valid_d;
      o_last_q      <= o_last_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_en_q   <= s1_en_d;
    s1_last_q <= s1_last_d;
    s1_data_q <= s1_data_d;
    s1_user_q <= s1_user_d;
    h_last_q  <= h_last_d;
    h_data_q  <= h_data_d;
    h_user_q  <= h_user_d;
    o_data_q  <= o_data_d;
    o_user_q  <= o_user_d;
  end

  // Writes go to the pre-swap shadow bank even when a swap lands in the same cycle
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mask_q[0][init_addr_q] <= 1'b1;
      mask_q[1][init_addr_q] <= 1'b1;
    end else if (mask_wr_en) begin
      mask_q[!active_sel_q][mask_wr_addr] <= mask_wr_data;
    end
  end

  assign mask_busy     = (state_q == StInit);
  assign m_axis_tvalid = o_valid_q;
  assign m_axis_tdata  = o_data_q;
  assign m_axis_tuser  = o_user_q;
  assign m_axis_tlast  = o_last_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_chan_bin_select.sv
// Directed bench for chan_bin_select: 8-bin frames through various masks, commits,
// fft_size limiting, output back-pressure and a mid-frame reset.
`timescale 1ns/1ps
module tb_chan_bin_select;
  logic        clk = 1'b0;
  logic        sync_reset;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic [23:0] s_axis_tuser;
  logic [11:0] fft_size;
  logic        mask_wr_en, mask_wr_data, mask_commit, mask_busy;
  logic [10:0] mask_wr_addr;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [23:0] m_axis_tuser;
  logic [15:0] frame_cnt;

  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  int          exp_fc = 0;
  int          acc_cyc [8];
  logic [63:0] out_q [$];
  int          out_cyc [$];
  int          stall_cnt = 0;
  int          stab_err = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_word = '0;

  chan_bin_select dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .fft_size      (fft_size),
    .mask_wr_en    (mask_wr_en),
    .mask_wr_addr  (mask_wr_addr),
    .mask_wr_data  (mask_wr_data),
    .mask_commit   (mask_commit),
    .mask_busy     (mask_busy),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_axis_tvalid && s_axis_tready) acc_cyc[s_axis_tuser[2:0]] <= cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      out_q.push_back({7'b0, m_axis_tlast, m_axis_tuser, m_axis_tdata});
      out_cyc.push_back(cyc);
    end
    if (s_axis_tvalid && !s_axis_tready && !mask_busy) stall_cnt <= stall_cnt + 1;
    if (sync_reset) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold && !(m_axis_tvalid &&
          {7'b0, m_axis_tlast, m_axis_tuser, m_axis_tdata} == prev_word))
        stab_err <= stab_err + 1;
      prev_hold <= m_axis_tvalid && !m_axis_tready;
      prev_word <= {7'b0, m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input int fid, input int b);
    return 32'((fid << 16) | b);
  endfunction

  function automatic logic [23:0] beat_user(input int fid, input int b);
    return {8'(fid), 5'h15, 11'(b)};
  endfunction

  task automatic send_beat(input int fid, input int b, input bit last, input bit commit);
    bit acc = 1'b0;
    int t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = beat_data(fid, b);
    s_axis_tuser  = beat_user(fid, b);
    s_axis_tlast  = last;
    mask_commit   = commit;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      mask_commit = 1'b0;
      t++;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) check_eq($sformatf("send_timeout_f%0d_b%0d", fid, b), 64'd0, 64'd1);
  endtask

  task automatic write_shadow(input logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      mask_wr_en   = 1'b1;
      mask_wr_addr = 11'(i);
      mask_wr_data = m[i];
      @(posedge clk);
      #1;
    end
    mask_wr_en = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int cnt = 0;
    while (mask_busy && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check_eq(tag, 64'(cnt), 64'd2048);
  endtask

  // Sends bins 0..7 (tlast on 7), drains, then compares against the enabled-bin list exp
  task automatic run_frame(input int fid, input logic [7:0] exp, input int commit_at,
                           input int lat);
    int n = 0;
    int k = 0;
    out_q.delete();
    out_cyc.delete();
    for (int b = 0; b < 8; b++) send_beat(fid, b, b == 7, b == commit_at);
    repeat (14) @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) if (exp[b]) n++;
    check_eq($sformatf("f%0d_beats", fid), 64'(out_q.size()), 64'(n));
    for (int b = 0; b < 8; b++) begin
      if (exp[b]) begin
        if (k < out_q.size())
          check_eq($sformatf("f%0d_bin%0d", fid, b), out_q[k],
                   {7'b0, (k == n - 1), beat_user(fid, b), beat_data(fid, b)});
        k++;
      end
    end
    if (lat >= 0 && n > 0 && out_q.size() == n)
      check_eq($sformatf("f%0d_latency", fid), 64'(out_cyc[n-1] - acc_cyc[7]), 64'(lat));
    if (n > 0) exp_fc++;
    check_eq($sformatf("f%0d_frame_cnt", fid), 64'(frame_cnt), 64'(exp_fc));
  endtask

  initial begin
    sync_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    fft_size      = 12'd8;
    mask_wr_en    = 1'b0;
    mask_wr_addr  = '0;
    mask_wr_data  = 1'b0;
    mask_commit   = 1'b0;
    m_axis_tready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(mask_busy), 64'd1);
    check_eq("rst_sready", 64'(s_axis_tready), 64'd0);
    check_eq("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_mlast", 64'(m_axis_tlast), 64'd0);
    check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    @(negedge clk);
    wait_busy("init_busy_cycles");

    run_frame(0, 8'h00, -1, -1);  // sync frame is discarded
    run_frame(1, 8'hFF, -1, 3);
    write_shadow(8'h24);
    mask_commit = 1'b1;
    @(posedge clk);
    #1;
    mask_commit = 1'b0;
    run_frame(2, 8'hFF, -1, 3);   // swap happens as this frame closes
    run_frame(3, 8'h24, -1, 2);
    write_shadow(8'h80);
    run_frame(4, 8'h24, 3, 2);    // commit mid-frame: old mask still in force
    run_frame(5, 8'h80, -1, 3);
    write_shadow(8'h00);
    run_frame(6, 8'h80, 0, 3);
    run_frame(7, 8'h00, -1, -1);
    write_shadow(8'hFF);
    run_frame(8, 8'h00, 0, -1);
    fft_size = 12'd4;
    run_frame(9, 8'h0F, -1, 2);   // bins 4..7 out of range, tlast flushes bin 3
    fft_size = 12'd8;
    write_shadow(8'h07);
    run_frame(10, 8'hFF, 0, 3);

    stall_cnt = 0;
    m_axis_tready = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
      end
    join_none
    run_frame(11, 8'h07, -1, -1);
    check_eq("stall_seen", 64'(stall_cnt >= 5), 64'd1);
    check_eq("hold_stable", 64'(stab_err), 64'd0);

    for (int b = 0; b < 4; b++) send_beat(12, b, 1'b0, 1'b0);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = beat_data(12, 4);
    s_axis_tuser  = beat_user(12, 4);
    s_axis_tlast  = 1'b0;
    sync_reset    = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_mvalid", 64'(m_axis_tvalid), 64'd1);
    @(posedge clk);
    #1;
    sync_reset    = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("mid_rst_mlast", 64'(m_axis_tlast), 64'd0);
    check_eq("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    wait_busy("mid_rst_busy_cycles");
    exp_fc = 0;
    run_frame(20, 8'h00, -1, -1);
    run_frame(21, 8'hFF, -1, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
